// File: rtl/ddfs_ctrl_pkg.sv
// Shared types and constants for the DDFS control slice (voice allocator, LRU).
package ddfs_ctrl_pkg;

  localparam int unsigned NUM_VOICES = 8;
  localparam int unsigned VIDX_W     = $clog2(NUM_VOICES);
  localparam int unsigned NOTE_W     = 7;
  localparam int unsigned FCCW_W     = 30;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned DATA_W     = 32;

  localparam logic [ADDR_W-1:0] DDFS_ADDR_FCCW  = 5'd0;
  localparam logic [ADDR_W-1:0] DDFS_ADDR_TRACK = 5'd5;

  typedef enum logic [2:0] {
    IDLE,
    ALLOC,
    WR_TRACK,
    WR_FCCW,
    DONE
  } state_t;

  // One slot-interface write beat toward the DDFS core.
  typedef struct packed {
    logic              cs;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ddfs_wr_t;

endpackage

// File: rtl/ddfs_voice_alloc_if.sv
// Request handshake, DDFS slot bus and status signals of the voice allocator.
interface ddfs_voice_alloc_if
  import ddfs_ctrl_pkg::*;
#(
  parameter int unsigned PW = FCCW_W
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_on;
  logic [NOTE_W-1:0]     req_note;
  logic [PW-1:0]         req_fccw;

  logic                  ddfs_cs;
  logic                  ddfs_write;
  logic [ADDR_W-1:0]     ddfs_addr;
  logic [DATA_W-1:0]     ddfs_wr_data;

  logic                  done;
  logic [VIDX_W-1:0]     done_voice;
  logic                  drop;
  logic                  steal;
  logic [NUM_VOICES-1:0] voice_active;

  modport slave (
    input  req_valid, req_on, req_note, req_fccw,
    output req_ready, ddfs_cs, ddfs_write, ddfs_addr, ddfs_wr_data,
    output done, done_voice, drop, steal, voice_active
  );

  modport master (
    output req_valid, req_on, req_note, req_fccw,
    input  req_ready, ddfs_cs, ddfs_write, ddfs_addr, ddfs_wr_data,
    input  done, done_voice, drop, steal, voice_active
  );

endinterface

// File: rtl/ddfs_voice_lru.sv
// Per-voice recency ranks (permutation of 0..NUM_VOICES-1); rank 0 = most recent.
module ddfs_voice_lru
  import ddfs_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              touch,
  input  logic [VIDX_W-1:0] touch_voice,
  output logic [VIDX_W-1:0] lru_voice_c
);

  logic [VIDX_W-1:0] rank_q [NUM_VOICES];

  // Touched voice moves to rank 0; everything more recent than it ages by one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_VOICES); i++) rank_q[i] <= VIDX_W'(i);
    end else if (touch) begin
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        if (VIDX_W'(i) == touch_voice) begin
          rank_q[i] <= '0;
        end else if (rank_q[i] < rank_q[touch_voice]) begin
          rank_q[i] <= rank_q[i] + VIDX_W'(1);
        end
      end
    end
  end

  always_comb begin
    lru_voice_c = '0;
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      if (rank_q[i] == VIDX_W'(NUM_VOICES - 1)) lru_voice_c = VIDX_W'(i);
    end
  end

endmodule

// File: rtl/ddfs_voice_alloc.sv
// Note-on/off to DDFS voice allocator issuing track-select then FCCW writes.
// Optional build macro: VOICE_STEAL_EN (steal LRU voice when all voices are busy).
module ddfs_voice_alloc
  import ddfs_ctrl_pkg::*;
#(
  parameter int unsigned PW = FCCW_W
)(
  input  logic               clk,
  input  logic               reset,
  ddfs_voice_alloc_if.slave  bus
);

  state_t state_q, state_d;

  logic              lat_on_q;
  logic [NOTE_W-1:0] lat_note_q;
  logic [PW-1:0]     lat_fccw_q;

  logic [VIDX_W-1:0] sel_voice_q, sel_voice_d;
  logic              sel_drop_q,  sel_drop_d;
  logic              sel_steal_q, sel_steal_d;

  logic [NUM_VOICES-1:0] active_q;
  logic [NOTE_W-1:0]     note_q [NUM_VOICES];

  ddfs_wr_t          wr_q, wr_d;
  logic              req_ready_q, req_ready_d;
  logic              done_q, done_d;
  logic [VIDX_W-1:0] done_voice_q, done_voice_d;
  logic              drop_q, drop_d;
  logic              steal_q, steal_d;

  logic              hit;
  logic [VIDX_W-1:0] hit_idx;
  logic              free;
  logic [VIDX_W-1:0] free_idx;
  logic [VIDX_W-1:0] lru_voice_c;
  logic              touch;
  logic              accept;

  assign accept = bus.req_valid & req_ready_q;
  assign touch  = (state_q == DONE) & lat_on_q & ~sel_drop_q;

  ddfs_voice_lru u_lru (
    .clk         (clk),
    .reset       (reset),
    .touch       (touch),
    .touch_voice (sel_voice_q),
    .lru_voice_c (lru_voice_c)
  );

`ifndef VOICE_STEAL_EN
  logic unused_lru;
  assign unused_lru = ^lru_voice_c;
`endif

  // Note-table lookup: lowest-index match and lowest-index free voice.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
      if (active_q[i] && (note_q[i] == lat_note_q)) begin
        hit     = 1'b1;
        hit_idx = VIDX_W'(i);
      end
      if (!active_q[i]) begin
        free     = 1'b1;
        free_idx = VIDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_voice_q <= '0;
      sel_drop_q  <= 1'b0;
      sel_steal_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_voice_q <= sel_voice_d;
      sel_drop_q  <= sel_drop_d;
      sel_steal_q <= sel_steal_d;
    end
  end

  // Next state plus next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    sel_voice_d  = sel_voice_q;
    sel_drop_d   = sel_drop_q;
    sel_steal_d  = sel_steal_q;
    wr_d         = '0;
    req_ready_d  = 1'b0;
    done_d       = 1'b0;
    done_voice_d = '0;
    drop_d       = 1'b0;
    steal_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) state_d = ALLOC;
      end
      ALLOC: begin
        sel_voice_d = '0;
        sel_drop_d  = 1'b0;
        sel_steal_d = 1'b0;
        if (lat_on_q) begin
          if (hit) begin
            sel_voice_d = hit_idx;
          end else if (free) begin
            sel_voice_d = free_idx;
          end else begin
`ifdef VOICE_STEAL_EN
            sel_voice_d = lru_voice_c;
            sel_steal_d = 1'b1;
`else
            sel_drop_d  = 1'b1;
`endif
          end
        end else if (hit) begin
          sel_voice_d = hit_idx;
        end else begin
          sel_drop_d = 1'b1;
        end
        state_d = sel_drop_d ? DONE : WR_TRACK;
      end
      WR_TRACK: state_d = WR_FCCW;
      WR_FCCW:  state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    case (state_d)
      IDLE: req_ready_d = 1'b1;
      WR_TRACK: begin
        wr_d.cs    = 1'b1;
        wr_d.write = 1'b1;
        wr_d.addr  = DDFS_ADDR_TRACK;
        wr_d.data  = DATA_W'(sel_voice_d);
      end
      WR_FCCW: begin
        wr_d.cs    = 1'b1;
        wr_d.write = 1'b1;
        wr_d.addr  = DDFS_ADDR_FCCW;
        wr_d.data  = lat_on_q ? DATA_W'(lat_fccw_q) : '0;
      end
      DONE: begin
        done_d       = 1'b1;
        done_voice_d = sel_voice_d;
        drop_d       = sel_drop_d;
        steal_d      = sel_steal_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q         <= '0;
      req_ready_q  <= 1'b1;
      done_q       <= 1'b0;
      done_voice_q <= '0;
      drop_q       <= 1'b0;
      steal_q      <= 1'b0;
    end else begin
      wr_q         <= wr_d;
      req_ready_q  <= req_ready_d;
      done_q       <= done_d;
      done_voice_q <= done_voice_d;
      drop_q       <= drop_d;
      steal_q      <= steal_d;
    end
  end

  // Request capture; the source holds its request stable until accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_on_q   <= 1'b0;
      lat_note_q <= '0;
      lat_fccw_q <= '0;
    end else if (accept) begin
      lat_on_q   <= bus.req_on;
      lat_note_q <= bus.req_note;
      lat_fccw_q <= bus.req_fccw;
    end
  end

  // Voice table commits when the request completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= '0;
      for (int i = 0; i < int'(NUM_VOICES); i++) note_q[i] <= '0;
    end else if ((state_q == DONE) && !sel_drop_q) begin
      if (lat_on_q) begin
        active_q[sel_voice_q] <= 1'b1;
        note_q[sel_voice_q]   <= lat_note_q;
      end else begin
        active_q[sel_voice_q] <= 1'b0;
        note_q[sel_voice_q]   <= '0;
      end
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.ddfs_cs      = wr_q.cs;
  assign bus.ddfs_write   = wr_q.write;
  assign bus.ddfs_addr    = wr_q.addr;
  assign bus.ddfs_wr_data = wr_q.data;
  assign bus.done         = done_q;
  assign bus.done_voice   = done_voice_q;
  assign bus.drop         = drop_q;
  assign bus.steal        = steal_q;
  assign bus.voice_active = active_q;

endmodule

// File: tb/tb_ddfs_voice_alloc.sv
// Directed self-checking bench for ddfs_voice_alloc (default and VOICE_STEAL_EN builds).
module tb_ddfs_voice_alloc;
  import ddfs_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  ddfs_voice_alloc_if #(.PW(30)) bus ();

  ddfs_voice_alloc #(.PW(30)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Per-cycle observations, index c = cycle T+c after acceptance at T.
  logic        obs_cs    [6];
  logic        obs_wr    [6];
  logic [4:0]  obs_addr  [6];
  logic [31:0] obs_data  [6];
  logic        obs_done  [6];
  logic [2:0]  obs_dv    [6];
  logic        obs_drop  [6];
  logic        obs_steal [6];
  logic        obs_ready [6];
  logic [7:0]  obs_va    [6];

  task automatic wait_ready();
    int n = 0;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_timeout: req_ready=%b required 1", bus.req_ready);
    end
  endtask

  // Present one request and record outputs for cycles T+1..T+5.
  task automatic issue(input logic on, input logic [6:0] note, input logic [29:0] fccw);
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_on    = on;
    bus.req_note  = note;
    bus.req_fccw  = fccw;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      obs_cs[c]    = bus.ddfs_cs;
      obs_wr[c]    = bus.ddfs_write;
      obs_addr[c]  = bus.ddfs_addr;
      obs_data[c]  = bus.ddfs_wr_data;
      obs_done[c]  = bus.done;
      obs_dv[c]    = bus.done_voice;
      obs_drop[c]  = bus.drop;
      obs_steal[c] = bus.steal;
      obs_ready[c] = bus.req_ready;
      obs_va[c]    = bus.voice_active;
      if (c < 5) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    int cs_seen = 0;
    checks++;
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b want 1", bus.req_ready); end
    checks++;
    if (bus.voice_active !== 8'h00) begin failures++; $display("FAIL rst_active: got %h want 00", bus.voice_active); end
    checks++;
    if ({bus.ddfs_cs, bus.ddfs_write, bus.ddfs_addr, bus.ddfs_wr_data} !== 39'd0) begin
      failures++; $display("FAIL rst_slot: cs=%b wr=%b addr=%h data=%h want all 0",
                           bus.ddfs_cs, bus.ddfs_write, bus.ddfs_addr, bus.ddfs_wr_data);
    end
    checks++;
    if ({bus.done, bus.drop, bus.steal, bus.done_voice} !== 6'd0) begin
      failures++; $display("FAIL rst_status: done=%b drop=%b steal=%b dv=%0d want 0",
                           bus.done, bus.drop, bus.steal, bus.done_voice);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.ddfs_cs) cs_seen++;
    end
    checks++;
    if (cs_seen != 0) begin failures++; $display("FAIL idle_cs: cs cycles=%0d want 0", cs_seen); end
  endtask

  task automatic test_note_on();
    issue(1'b1, 7'd60, 30'h0123456);
    checks++;
    if (obs_cs[1] !== 1'b0 || obs_ready[1] !== 1'b0) begin
      failures++; $display("FAIL on_alloc: cs=%b ready=%b want 0 0", obs_cs[1], obs_ready[1]);
    end
    checks++;
    if (obs_cs[2] !== 1'b1 || obs_wr[2] !== 1'b1 || obs_addr[2] !== 5'd5 || obs_data[2] !== 32'd0) begin
      failures++; $display("FAIL on_track: cs=%b wr=%b addr=%0d data=%h want 1 1 5 0",
                           obs_cs[2], obs_wr[2], obs_addr[2], obs_data[2]);
    end
    checks++;
    if (obs_cs[3] !== 1'b1 || obs_wr[3] !== 1'b1 || obs_addr[3] !== 5'd0 || obs_data[3] !== 32'h00123456) begin
      failures++; $display("FAIL on_fccw: cs=%b wr=%b addr=%0d data=%h want 1 1 0 00123456",
                           obs_cs[3], obs_wr[3], obs_addr[3], obs_data[3]);
    end
    checks++;
    if (obs_done[4] !== 1'b1 || obs_dv[4] !== 3'd0 || obs_drop[4] !== 1'b0 || obs_steal[4] !== 1'b0 || obs_cs[4] !== 1'b0) begin
      failures++; $display("FAIL on_done: done=%b dv=%0d drop=%b steal=%b cs=%b want 1 0 0 0 0",
                           obs_done[4], obs_dv[4], obs_drop[4], obs_steal[4], obs_cs[4]);
    end
    checks++;
    if (obs_ready[5] !== 1'b1 || obs_done[5] !== 1'b0 || obs_va[5] !== 8'h01) begin
      failures++; $display("FAIL on_after: ready=%b done=%b active=%h want 1 0 01",
                           obs_ready[5], obs_done[5], obs_va[5]);
    end
  endtask

  task automatic test_retrigger();
    issue(1'b1, 7'd60, 30'h0200000);
    checks++;
    if (obs_data[2] !== 32'd0 || obs_data[3] !== 32'h00200000) begin
      failures++; $display("FAIL retrig_writes: track=%h fccw=%h want 0 00200000", obs_data[2], obs_data[3]);
    end
    checks++;
    if (obs_dv[4] !== 3'd0 || obs_va[5] !== 8'h01) begin
      failures++; $display("FAIL retrig_voice: dv=%0d active=%h want 0 01", obs_dv[4], obs_va[5]);
    end
  endtask

  task automatic test_fill_and_overflow();
    for (int k = 1; k <= 7; k++) begin
      issue(1'b1, 7'(60 + k), 30'(32'h1000 + k));
      checks++;
      if (obs_data[2] !== 32'(k) || obs_data[3] !== 32'(32'h1000 + k)) begin
        failures++; $display("FAIL fill_writes k=%0d: track=%h fccw=%h want %h %h",
                             k, obs_data[2], obs_data[3], 32'(k), 32'(32'h1000 + k));
      end
      checks++;
      if (obs_dv[4] !== 3'(k)) begin
        failures++; $display("FAIL fill_voice k=%0d: dv=%0d want %0d", k, obs_dv[4], k);
      end
    end
    checks++;
    if (bus.voice_active !== 8'hFF) begin failures++; $display("FAIL fill_active: got %h want FF", bus.voice_active); end

    issue(1'b1, 7'd70, 30'h0777777);
`ifdef VOICE_STEAL_EN
    checks++;
    if (obs_cs[2] !== 1'b1 || obs_data[2] !== 32'd0 || obs_data[3] !== 32'h00777777) begin
      failures++; $display("FAIL steal_writes: cs=%b track=%h fccw=%h want 1 0 00777777",
                           obs_cs[2], obs_data[2], obs_data[3]);
    end
    checks++;
    if (obs_done[4] !== 1'b1 || obs_steal[4] !== 1'b1 || obs_drop[4] !== 1'b0 || obs_dv[4] !== 3'd0) begin
      failures++; $display("FAIL steal_done: done=%b steal=%b drop=%b dv=%0d want 1 1 0 0",
                           obs_done[4], obs_steal[4], obs_drop[4], obs_dv[4]);
    end
    checks++;
    if (obs_va[5] !== 8'hFF) begin failures++; $display("FAIL steal_active: got %h want FF", obs_va[5]); end
`else
    checks++;
    if (obs_cs[1] !== 1'b0 || obs_cs[2] !== 1'b0 || obs_cs[3] !== 1'b0) begin
      failures++; $display("FAIL full_cs: cs T+1..3=%b%b%b want 000", obs_cs[1], obs_cs[2], obs_cs[3]);
    end
    checks++;
    if (obs_done[2] !== 1'b1 || obs_drop[2] !== 1'b1 || obs_steal[2] !== 1'b0) begin
      failures++; $display("FAIL full_drop: done=%b drop=%b steal=%b want 1 1 0",
                           obs_done[2], obs_drop[2], obs_steal[2]);
    end
    checks++;
    if (obs_ready[3] !== 1'b1 || obs_va[5] !== 8'hFF) begin
      failures++; $display("FAIL full_after: ready=%b active=%h want 1 FF", obs_ready[3], obs_va[5]);
    end
`endif
  endtask

  task automatic test_note_off();
    int cs_seen = 0;
    issue(1'b0, 7'd62, 30'h3FFFFFF);
    checks++;
    if (obs_cs[2] !== 1'b1 || obs_addr[2] !== 5'd5 || obs_data[2] !== 32'd2) begin
      failures++; $display("FAIL off_track: cs=%b addr=%0d data=%h want 1 5 2", obs_cs[2], obs_addr[2], obs_data[2]);
    end
    checks++;
    if (obs_cs[3] !== 1'b1 || obs_addr[3] !== 5'd0 || obs_data[3] !== 32'd0) begin
      failures++; $display("FAIL off_fccw: cs=%b addr=%0d data=%h want 1 0 0", obs_cs[3], obs_addr[3], obs_data[3]);
    end
    checks++;
    if (obs_done[4] !== 1'b1 || obs_dv[4] !== 3'd2 || obs_drop[4] !== 1'b0 || obs_va[5] !== 8'hFB) begin
      failures++; $display("FAIL off_done: done=%b dv=%0d drop=%b active=%h want 1 2 0 FB",
                           obs_done[4], obs_dv[4], obs_drop[4], obs_va[5]);
    end

    issue(1'b0, 7'd99, 30'h0);
    for (int c = 1; c <= 5; c++) if (obs_cs[c]) cs_seen++;
    checks++;
    if (cs_seen != 0) begin failures++; $display("FAIL off_miss_cs: cs cycles=%0d want 0", cs_seen); end
    checks++;
    if (obs_done[2] !== 1'b1 || obs_drop[2] !== 1'b1 || obs_va[5] !== 8'hFB) begin
      failures++; $display("FAIL off_miss_drop: done=%b drop=%b active=%h want 1 1 FB",
                           obs_done[2], obs_drop[2], obs_va[5]);
    end
  endtask

  task automatic test_reset_mid();
    int cs_seen = 0;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_on    = 1'b1;
    bus.req_note  = 7'd80;
    bus.req_fccw  = 30'h0ABCDEF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.ddfs_cs !== 1'b1 || bus.ddfs_addr !== 5'd5 || bus.ddfs_wr_data !== 32'd2) begin
      failures++; $display("FAIL mid_track: cs=%b addr=%0d data=%h want 1 5 2",
                           bus.ddfs_cs, bus.ddfs_addr, bus.ddfs_wr_data);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.ddfs_cs, bus.ddfs_write, bus.ddfs_addr, bus.ddfs_wr_data} !== 39'd0) begin
      failures++; $display("FAIL mid_slot: cs=%b wr=%b addr=%h data=%h want all 0",
                           bus.ddfs_cs, bus.ddfs_write, bus.ddfs_addr, bus.ddfs_wr_data);
    end
    checks++;
    if (bus.req_ready !== 1'b1 || bus.voice_active !== 8'h00 || bus.done !== 1'b0) begin
      failures++; $display("FAIL mid_state: ready=%b active=%h done=%b want 1 00 0",
                           bus.req_ready, bus.voice_active, bus.done);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.ddfs_cs || bus.done) cs_seen++;
    end
    checks++;
    if (cs_seen != 0 || bus.voice_active !== 8'h00) begin
      failures++; $display("FAIL mid_after: activity cycles=%0d active=%h want 0 00", cs_seen, bus.voice_active);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_on    = 1'b0;
    bus.req_note  = '0;
    bus.req_fccw  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_note_on();
    test_retrigger();
    test_fill_and_overflow();
    test_note_off();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddfs_voice_alloc.md
# ddfs_voice_alloc

Voice allocator and write sequencer for the 8-voice DDFS core. It accepts note-on/note-off requests over a valid/ready handshake and maps each note to one of the 8 DDFS voices. It then issues the two-write register sequence (track select, then FCCW) on the core's slot interface. It sits between the note source (MMIO slot or MIDI parser) and the DDFS core, and is the only writer of the core's track and FCCW registers.

## Interface

- PW, 30, DDFS phase/FCCW width; must match the DDFS core
- NV, 8, number of voices; fixed at 8 (3-bit voice index)

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_on  in  1  1 = note-on, 0 = note-off
- req_note  in  7  note/key identifier
- req_fccw  in  PW  frequency control word for note-on; ignored for note-off
- ddfs_cs  out  1  slot chip-select to DDFS core
- ddfs_write  out  1  slot write strobe
- ddfs_addr  out  5  slot register address
- ddfs_wr_data  out  32  slot write data, zero-extended
- done  out  1  one-cycle pulse when a request completes
- done_voice  out  3  voice used by the completed request; valid with done
- drop  out  1  with done: request rejected, no writes issued
- steal  out  1  with done: an active voice was reassigned
- voice_active  out  8  bit i = voice i currently holds a note

## Operation

- FSM states: IDLE, ALLOC, WR_TRACK, WR_FCCW, DONE.
- req_ready = 1 only in IDLE. A request is accepted on a cycle with req_valid & req_ready. The request is latched, and the FSM moves to ALLOC.
- ALLOC, note-on, evaluated in priority order:
  - an active voice already holds req_note: retrigger that voice
  - else lowest-index inactive voice
  - else steal the LRU voice (see Configuration)
- ALLOC, note-off:
  - the active voice holding req_note is selected and its FCCW is set to 0
  - with no match: drop = 1, skip to DONE
- WR_TRACK: ddfs_cs = ddfs_write = 1, ddfs_addr = 5, ddfs_wr_data = {29'b0, voice}.
- WR_FCCW: ddfs_cs = ddfs_write = 1, ddfs_addr = 0, ddfs_wr_data = zero-extended FCCW (req_fccw for note-on, 0 for note-off).
- DONE: done = 1 for one cycle, with done_voice, drop and steal. voice_active and per-voice note table update in this cycle (set on note-on, clear on note-off). Next state IDLE.
- LRU:
  - each voice holds a 3-bit rank, forming a permutation of 0..7
  - on every note-on at DONE, ranks below the chosen voice's rank increment and the chosen voice's rank becomes 0
  - LRU voice = rank 7
  - note-off does not change ranks
- Outside WR_TRACK/WR_FCCW: ddfs_cs, ddfs_write = 0; ddfs_addr, ddfs_wr_data = 0.

## Timing

- Accept at cycle T. ALLOC at T+1, WR_TRACK at T+2, WR_FCCW at T+3, DONE at T+4. req_ready is high again at T+5.
- Drop path: ALLOC at T+1, DONE at T+2.
- Track is always written one cycle before FCCW. The DDFS core latches FCCW into the selected voice on the following cycles.
- Reset values:
  - state IDLE, req_ready = 1
  - all slot outputs 0
  - done, drop, steal, done_voice = 0
  - voice_active = 0, note table = 0
  - rank[i] = i
- Reset mid-sequence aborts immediately and asynchronously. No further writes are issued. The DDFS core keeps whatever was already written.
- req_valid while busy is held off by req_ready = 0. The source must hold its request stable until accepted.

## Configuration

- VOICE_STEAL_EN defined: note-on with all 8 voices active steals the rank-7 voice. Writes are issued, and done reports steal = 1.
- VOICE_STEAL_EN undefined: that note-on is dropped (drop = 1, no writes, DONE at T+2). Steal logic and the steal output are tied to 0.

## Structure

- Package ddfs_ctrl_pkg holds:
  - state enum
  - NUM_VOICES = 8
  - register address constants DDFS_ADDR_FCCW = 5'd0, DDFS_ADDR_TRACK = 5'd5
- Sub-module ddfs_voice_lru holds the rank array. It has a touch strobe plus voice index input and an LRU index output.

## Test plan

- Reset, then idle -> req_ready = 1, voice_active = 8'h00, no ddfs_cs for 20 cycles.
- Note-on note 60, fccw 30'h0123456 at T:
  - T+2: addr 5, data 0
  - T+3: addr 0, data 32'h00123456
  - T+4: done with done_voice = 0
  - afterwards: voice_active = 8'h01
- Note-on note 60 again -> retriggers voice 0; voice_active stays 8'h01.
- Notes 61..67 fill voices 1..7, then note-on 70:
  - with VOICE_STEAL_EN: voice 0 stolen, steal = 1, voice_active = 8'hFF
  - without VOICE_STEAL_EN: drop = 1 at T+2, no cs
- Note-off note 62 -> voice 2 is written with FCCW 0, bit 2 clears. Note-off note 99 -> drop = 1, no writes.
- Assert reset during WR_TRACK -> ddfs_cs drops in the same cycle, no FCCW write, all outputs at reset values.
